// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: turns a simple dual-port RAM (registered address, one-cycle
// read latency) into a streaming FIFO with valid/ready on both sides.
//
// Handshake semantics: a word moves on a side in any cycle where valid and
// ready are both high at the rising edge; valid never depends on ready.
//
// Words flow RAM -> (one read in flight) -> 2-entry output buffer. The
// output buffer is sized so that a read can be issued every cycle while the
// consumer pops every cycle, giving one word per clock after the first fill.
module ram_fifo_ctrl #(
    parameter int ADDR_SIZE = 7,
    parameter int DATA_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_SIZE-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_SIZE-1:0] m_data,
    output logic [ADDR_SIZE+1:0] level,
    output logic                 ram_wren,
    output logic [ADDR_SIZE-1:0] ram_waddr,
    output logic [DATA_SIZE-1:0] ram_d,
    output logic                 ram_rden,
    output logic [ADDR_SIZE-1:0] ram_raddr,
    input  logic [DATA_SIZE-1:0] ram_q
);

    // Full count: DEPTH = 2**ADDR_SIZE, held in ADDR_SIZE+1 bits.
    localparam logic [ADDR_SIZE:0] DEPTH_C = {1'b1, {ADDR_SIZE{1'b0}}};

    logic [ADDR_SIZE-1:0]        wptr_q, wptr_d;
    logic [ADDR_SIZE-1:0]        rptr_q, rptr_d;
    logic [ADDR_SIZE:0]          mem_cnt_q, mem_cnt_d;
    logic                        rd_pend_q, rd_pend_d;
    logic [1:0]                  out_occ_q, out_occ_d;
    logic                        out_hd_q, out_hd_d;
    logic [1:0][DATA_SIZE-1:0]   out_buf_q, out_buf_d;

    logic                        push;
    logic                        pop;
    logic                        rd_issue;
    logic [2:0]                  buf_need;
    logic                        tail_idx;

    // Handshake and read-issue decisions, all from registered state.
    always_comb begin
        s_ready  = reset_n && !flush && (mem_cnt_q < DEPTH_C);
        push     = s_valid && s_ready;
        m_valid  = (out_occ_q != 2'd0);
        pop      = m_valid && m_ready && !flush;
        // Buffer slots that will be occupied once the in-flight read lands,
        // after this cycle's pop; a new read needs one slot left over.
        buf_need = {1'b0, out_occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
        rd_issue = (mem_cnt_q != '0) && !flush && (buf_need <= 3'd1);
        // A capture only happens with at most one buffered word, so the tail
        // slot is the head slot or the other one.
        tail_idx = out_hd_q ^ out_occ_q[0];
    end

    // Next-state computation; flush returns everything to the reset image.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        mem_cnt_d = mem_cnt_q;
        rd_pend_d = 1'b0;
        out_occ_d = out_occ_q;
        out_hd_d  = out_hd_q;
        out_buf_d = out_buf_q;
        if (flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            mem_cnt_d = '0;
            out_occ_d = '0;
            out_hd_d  = 1'b0;
            out_buf_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (rd_issue) begin
                rptr_d = rptr_q + 1'b1;
            end
            mem_cnt_d = mem_cnt_q + {{ADDR_SIZE{1'b0}}, push}
                                  - {{ADDR_SIZE{1'b0}}, rd_issue};
            rd_pend_d = rd_issue;
            if (rd_pend_q) begin
                out_buf_d[tail_idx] = ram_q;
            end
            if (pop) begin
                out_hd_d = ~out_hd_q;
            end
            out_occ_d = out_occ_q + {1'b0, rd_pend_q} - {1'b0, pop};
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            mem_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            out_occ_q <= '0;
            out_hd_q  <= 1'b0;
            out_buf_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            mem_cnt_q <= mem_cnt_d;
            rd_pend_q <= rd_pend_d;
            out_occ_q <= out_occ_d;
            out_hd_q  <= out_hd_d;
            out_buf_q <= out_buf_d;
        end
    end

    // RAM port drive, output data and occupancy.
    always_comb begin
        ram_wren  = push;
        ram_waddr = wptr_q;
        ram_d     = s_data;
        ram_rden  = rd_issue;
        ram_raddr = rptr_q;
        m_data    = out_buf_q[out_hd_q];
        level     = {1'b0, mem_cnt_q}
                  + {{(ADDR_SIZE+1){1'b0}}, rd_pend_q}
                  + {{ADDR_SIZE{1'b0}}, out_occ_q};
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: behavioural RAM, queue-based reference model,
// directed latency/fill/flush/reset scenarios plus randomized backpressure.
module tb_ram_fifo_ctrl;

    localparam int AW    = 7;
    localparam int DW    = 16;
    localparam int DEPTH = 2**AW;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW+1:0] level;
    logic          ram_wren;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_d;
    logic          ram_rden;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_q;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int pop_cnt  = 0;
    int pop_cyc_q[$];
    logic [DW-1:0] exp_q[$];

    ram_fifo_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .level     (level),
        .ram_wren  (ram_wren),
        .ram_waddr (ram_waddr),
        .ram_d     (ram_d),
        .ram_rden  (ram_rden),
        .ram_raddr (ram_raddr),
        .ram_q     (ram_q)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural RAM ----------------
    logic [DW-1:0] ram_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_waddr] <= ram_d;
        if (ram_rden) ram_q <= ram_mem[ram_raddr];
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- scoreboard monitor ----------------
    // Reference model: the FIFO is just the ordered list of accepted words.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            chk("level", level, exp_q.size());
            if (exp_q.size() == 0) chk("m_valid_empty", m_valid, 0);
            if (!flush && level < DEPTH) chk("s_ready_space", s_ready, 1);
            if (level == DEPTH + 2) chk("s_ready_full", s_ready, 0);
            chk("ram_wren", ram_wren, s_valid && s_ready);
            if (ram_wren && ram_rden) chk("rw_same_addr", ram_waddr != ram_raddr, 1);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_underflow", m_valid, 0);
                    end else begin
                        chk("m_data", m_data, exp_q.pop_front());
                        pop_cnt++;
                        pop_cyc_q.push_back(cyc);
                    end
                end
                if (s_valid && s_ready) exp_q.push_back(s_data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All driver tasks start and end at posedge+1.
    task automatic push_word(input logic [DW-1:0] d);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("push_timeout", s_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        while (level != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", level, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_ram_wren"}, ram_wren, 0);
        chk({tag, "_ram_rden"}, ram_rden, 0);
    endtask

    // One word into an empty FIFO straight after reset.
    task automatic single_word();
        s_valid = 1'b1;
        s_data  = 16'h1234;
        m_ready = 1'b1;
        @(negedge clk);
        chk("sw_wren", ram_wren, 1);
        chk("sw_waddr", ram_waddr, 0);
        chk("sw_wdata", ram_d, 16'h1234);
        chk("sw_no_early_rden", ram_rden, 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("sw_rden", ram_rden, 1);
        chk("sw_raddr", ram_raddr, 0);
        chk("sw_mvalid_e1", m_valid, 0);
        chk("sw_level_e1", level, 1);
        @(negedge clk);
        chk("sw_mvalid_e2", m_valid, 0);
        chk("sw_level_e2", level, 1);
        @(negedge clk);
        chk("sw_mvalid_e3", m_valid, 1);
        chk("sw_mdata_e3", m_data, 16'h1234);
        @(negedge clk);
        chk("sw_mvalid_after_pop", m_valid, 0);
        chk("sw_level_after_pop", level, 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int c0;
        int acc;
        int lows;
        int sent;
        int guard;
        int n;
        reset_n = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        #2;
        chk_reset_outs("por");
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word latency
        single_word();

        // Streaming 300 words, both pointers wrap
        m_ready = 1'b1;
        pop_cyc_q.delete();
        c0 = cyc;
        for (int i = 0; i < 300; i++) push_word(16'(i));
        chk("stream_in_rate", cyc - c0, 300);
        s_valid = 1'b0;
        n = 0;
        while (pop_cyc_q.size() < 300 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("stream_pop_count", pop_cyc_q.size(), 300);
        if (pop_cyc_q.size() >= 300) chk("stream_no_bubbles", pop_cyc_q[299] - pop_cyc_q[0], 299);
        drain();

        // Fill until full with no consumer
        m_ready = 1'b0;
        s_valid = 1'b1;
        acc = 0;
        lows = 0;
        for (int i = 0; i < 200 && lows < 5; i++) begin
            s_data = 16'(16'h1000 + i);
            @(negedge clk);
            if (s_ready) acc++;
            else lows++;
            @(posedge clk);
            #1;
        end
        chk("fill_accepted", acc, DEPTH + 2);
        chk("fill_ready_low", lows, 5);
        @(negedge clk);
        chk("fill_level", level, DEPTH + 2);
        chk("fill_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("fill_pop_cycle_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        chk("fill_after_read_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        drain();

        // Flush with traffic on both sides
        m_ready = 1'b0;
        for (int i = 0; i < 50; i++) push_word(16'(16'h2000 + i));
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h5555;
        m_ready = 1'b1;
        @(negedge clk);
        chk("flush_s_ready", s_ready, 0);
        chk("flush_ram_wren", ram_wren, 0);
        chk("flush_ram_rden", ram_rden, 0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("flush_level", level, 0);
        chk("flush_m_valid", m_valid, 0);
        @(posedge clk);
        #1;
        push_word(16'hABCD);
        s_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("flush_first_word", m_data, 16'hABCD);
        @(posedge clk);
        #1;
        drain();

        // Randomized backpressure, 2000 words
        sent = 0;
        guard = 0;
        s_valid = 1'b0;
        while (sent < 2000 && guard < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (!s_valid) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = 16'($urandom_range(0, 16'hFFFF));
            end
            @(negedge clk);
            if (s_valid && s_ready) begin
                sent++;
                s_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        s_valid = 1'b0;
        chk("random_sent", sent, 2000);
        drain();

        // Asynchronous reset mid-stream
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) push_word(16'(16'h3000 + i));
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outs("arst");
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        single_word();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
